beam_direction_detector: RTL

Front-end for the drawbridge deck occupancy counter. Two beam-break sensors, A (land side) and B (deck side), are spaced so that a passing item blocks both at once for part of its transit. This block synchronizes and debounces both beams and tracks the blocking order. It emits one single-cycle `up` pulse per completed A→B passage and one `down` pulse per completed B→A passage; these feed the counter's `up`/`down` inputs directly.

---
 rtl/beam_direction_detector.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/beam_direction_detector.sv
// Beam-break direction detector: synchronizes and debounces two beams, then tracks
// blocking order to emit up/down passage pulses. Optional input synchronizer: BEAM_SYNC_EN.
module beam_direction_detector #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       beam_a,
   input  logic       beam_b,
   output logic       up,
   output logic       down,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_F1    = 3'd1,
      ST_F2    = 3'd2,
      ST_F3    = 3'd3,
      ST_R1    = 3'd4,
      ST_R2    = 3'd5,
      ST_R3    = 3'd6,
      ST_ABORT = 3'd7
   } state_e;

   localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [19:0] DWELL_LAST = 20'(TIMEOUT_CYCLES - 1);

   logic a_sync;
   logic b_sync;

`ifdef BEAM_SYNC_EN
   logic [1:0] a_sync_q, a_sync_d;
   logic [1:0] b_sync_q, b_sync_d;

   always_comb begin
      a_sync_d = {a_sync_q[0], beam_a};
      b_sync_d = {b_sync_q[0], beam_b};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_sync_q <= '0;
         b_sync_q <= '0;
      end else begin
         a_sync_q <= a_sync_d;
         b_sync_q <= b_sync_d;
      end
   end

   assign a_sync = a_sync_q[1];
   assign b_sync = b_sync_q[1];
`else
   assign a_sync = beam_a;
   assign b_sync = beam_b;
`endif

   // Bit 1 is beam A, bit 0 is beam B, matching the {A,B} transition notation.
   logic [1:0]      sync_ab;
   logic [1:0]      deb_q, deb_d;
   logic [1:0][7:0] cnt_q, cnt_d;

   assign sync_ab = {a_sync, b_sync};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync_ab[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync_ab[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_q <= '0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   state_e      state_q, state_d;
   logic [19:0] dwell_q, dwell_d;
   logic        up_q, up_d;
   logic        down_q, down_d;
   logic        fault_q, fault_d;
   logic        tracking;

   assign tracking = (state_q != ST_IDLE) && (state_q != ST_ABORT);

   always_comb begin
      state_d = state_q;
      up_d    = 1'b0;
      down_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            case (deb_q)
               2'b10:   state_d = ST_F1;
               2'b01:   state_d = ST_R1;
               2'b11:   state_d = ST_ABORT;
               default: state_d = ST_IDLE;
            endcase
         end
         ST_F1: begin
            case (deb_q)
               2'b11:   state_d = ST_F2;
               2'b00:   state_d = ST_IDLE;
               2'b01:   state_d = ST_ABORT;
               default: state_d = ST_F1;
            endcase
         end
         ST_F2: begin
            case (deb_q)
               2'b01:   state_d = ST_F3;
               2'b10:   state_d = ST_F1;
               2'b00:   state_d = ST_ABORT;
               default: state_d = ST_F2;
            endcase
         end
         ST_F3: begin
            case (deb_q)
               2'b00: begin
                  state_d = ST_IDLE;
                  up_d    = 1'b1;
               end
               2'b11:   state_d = ST_F2;
               2'b10:   state_d = ST_ABORT;
               default: state_d = ST_F3;
            endcase
         end
         ST_R1: begin
            case (deb_q)
               2'b11:   state_d = ST_R2;
               2'b00:   state_d = ST_IDLE;
               2'b10:   state_d = ST_ABORT;
               default: state_d = ST_R1;
            endcase
         end
         ST_R2: begin
            case (deb_q)
               2'b10:   state_d = ST_R3;
               2'b01:   state_d = ST_R1;
               2'b00:   state_d = ST_ABORT;
               default: state_d = ST_R2;
            endcase
         end
         ST_R3: begin
            case (deb_q)
               2'b00: begin
                  state_d = ST_IDLE;
                  down_d  = 1'b1;
               end
               2'b11:   state_d = ST_R2;
               2'b01:   state_d = ST_ABORT;
               default: state_d = ST_R3;
            endcase
         end
         ST_ABORT: begin
            if (deb_q == 2'b00) state_d = ST_IDLE;
         end
         default: state_d = ST_ABORT;
      endcase

      // A stuck passage overrides whatever the inputs would have done this cycle.
      if (tracking && (dwell_q == DWELL_LAST)) begin
         state_d = ST_ABORT;
         up_d    = 1'b0;
         down_d  = 1'b0;
      end

      if ((state_d != state_q) || !tracking) begin
         dwell_d = '0;
      end else begin
         dwell_d = dwell_q + 20'd1;
      end

      fault_d = (state_d == ST_ABORT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         dwell_q <= '0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         up_q    <= up_d;
         down_q  <= down_d;
         fault_q <= fault_d;
      end
   end

   assign up    = up_q;
   assign down  = down_q;
   assign fault = fault_q;
   assign state = state_q;

endmodule
